mpt_plb: RTL and testbench

//  Parametrised Permission Lookaside Buffer caching MPT walk results per supervisor domain (SDID).

---
 rtl/mpt_plb_pkg.sv | 73 +++++++
 rtl/mpt_plb_victim_sel.sv | 40 ++++
 rtl/mpt_plb.sv | 170 +++++++++++++++++
 tb/tb_mpt_plb.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpt_plb_pkg.sv
// Shared types and helpers for the MPT permission lookaside buffer.
// Entry layout, access/permission encodings and the size-dependent tag mask.
package mpt_plb_pkg;

  localparam int unsigned PLEN_DEF     = 34;
  localparam int unsigned SDID_LEN_DEF = 6;
  localparam int unsigned L2_SHIFT_DEF = 25;
  localparam int unsigned SHIFT_4K     = 12;
  localparam int unsigned SHIFT_4M     = 22;
  localparam int unsigned TAG_W        = PLEN_DEF - SHIFT_4K;

  typedef enum logic [1:0] {
    MPT_BARE = 2'd0,
    MPT_34   = 2'd1,
    MPT_43   = 2'd2,
    MPT_52   = 2'd3
  } mpt_mode_e;

  typedef enum logic [1:0] {
    ACCESS_NONE  = 2'd0,
    ACCESS_READ  = 2'd1,
    ACCESS_WRITE = 2'd2,
    ACCESS_EXEC  = 2'd3
  } mpt_access_e;

  typedef enum logic [1:0] {
    DISALLOWED = 2'd0,
    ALLOW_RX   = 2'd1,
    ALLOW_RW   = 2'd2,
    ALLOW_RWX  = 2'd3
  } mpt_permissions_e;

  typedef enum logic [1:0] {
    SIZE_4K   = 2'd0,
    SIZE_4M   = 2'd1,
    SIZE_L2   = 2'd2,
    SIZE_RSVD = 2'd3
  } plb_size_e;

  typedef struct packed {
    logic                    valid;
    logic [SDID_LEN_DEF-1:0] sdid;
    logic [TAG_W-1:0]        tag;
    plb_size_e               size;
    mpt_permissions_e        perm;
  } plb_tag_entry_t;

  function automatic logic perm_allows(mpt_permissions_e perm, mpt_access_e access);
    logic ok;
    ok = 1'b0;
    case (access)
      ACCESS_READ:  ok = (perm == ALLOW_RX) || (perm == ALLOW_RW) || (perm == ALLOW_RWX);
      ACCESS_WRITE: ok = (perm == ALLOW_RW) || (perm == ALLOW_RWX);
      ACCESS_EXEC:  ok = (perm == ALLOW_RX) || (perm == ALLOW_RWX);
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Tag bits (relative to bit 12) that take part in a compare for a given page size.
  function automatic logic [TAG_W-1:0] tag_mask(plb_size_e size, int unsigned l2_shift);
    logic [TAG_W-1:0] m;
    int unsigned      lo;
    case (size)
      SIZE_L2: lo = l2_shift - SHIFT_4K;
      SIZE_4M: lo = SHIFT_4M - SHIFT_4K;
      default: lo = 0;
    endcase
    for (int unsigned b = 0; b < TAG_W; b++) m[b] = (b >= lo);
    return m;
  endfunction

endpackage

// File: rtl/mpt_plb_victim_sel.sv
// Refill slot choice: lowest invalid entry first, else a round-robin pointer
// that only moves when a valid entry is actually evicted.
module mpt_plb_victim_sel
  import mpt_plb_pkg::*;
#(
  parameter int unsigned ENTRIES = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [ENTRIES-1:0]         valid_i,
  input  logic                       alloc_i,
  output logic [$clog2(ENTRIES)-1:0] victim_idx_c
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             have_free;

  always_comb begin
    have_free    = 1'b0;
    victim_idx_c = ptr_q;
    ptr_d        = ptr_q;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!have_free && !valid_i[i]) begin
        have_free    = 1'b1;
        victim_idx_c = IDX_W'(i);
      end
    end
    if (alloc_i && !have_free) begin
      ptr_d = (ptr_q == IDX_W'(ENTRIES - 1)) ? '0 : ptr_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mpt_plb.sv
// Fully-associative permission lookaside buffer for MPT walk results, keyed by SDID.
// One-cycle registered lookup, walker refill with dedup, global/selective flush, hit/miss counters.
module mpt_plb
  import mpt_plb_pkg::*;
#(
  parameter int unsigned PLB_ENTRIES = 8,
  parameter int unsigned PLEN        = PLEN_DEF,
  parameter int unsigned SDID_LEN    = SDID_LEN_DEF,
  parameter int unsigned L2_SHIFT    = L2_SHIFT_DEF,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  mpt_mode_e           mode_i,
  input  logic                lkp_valid_i,
  input  logic [PLEN-1:0]     lkp_spa_i,
  input  logic [SDID_LEN-1:0] lkp_sdid_i,
  input  mpt_access_e         lkp_access_i,
  output logic                resp_valid_o,
  output logic                resp_hit_o,
  output logic                resp_allowed_o,
  output mpt_permissions_e    resp_perm_o,
  input  logic                refill_valid_i,
  input  logic [PLEN-1:0]     refill_spa_i,
  input  logic [SDID_LEN-1:0] refill_sdid_i,
  input  plb_size_e           refill_size_i,
  input  mpt_permissions_e    refill_perm_i,
  input  logic                flush_i,
  input  logic                flush_sdid_en_i,
  input  logic [SDID_LEN-1:0] flush_sdid_i,
  output logic [CNT_W-1:0]    hit_cnt_o,
  output logic [CNT_W-1:0]    miss_cnt_o
);

  localparam int unsigned     IDX_W   = $clog2(PLB_ENTRIES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  plb_tag_entry_t   entries_q [PLB_ENTRIES];
  plb_tag_entry_t   entries_d [PLB_ENTRIES];
  logic             resp_valid_q, resp_valid_d;
  logic             resp_hit_q, resp_hit_d;
  logic             resp_allowed_q, resp_allowed_d;
  mpt_permissions_e resp_perm_q, resp_perm_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  logic [TAG_W-1:0]       lkp_tag, refill_tag;
  logic                   lkp_hit_c;
  mpt_permissions_e       lkp_perm_c;
  logic                   dedup_hit_c;
  logic [IDX_W-1:0]       dedup_idx_c;
  logic [IDX_W-1:0]       victim_idx_c;
  logic [PLB_ENTRIES-1:0] valid_vec;
  logic                   refill_drop, refill_do, refill_alloc;
  logic                   unused_low_bits;

  assign lkp_tag         = lkp_spa_i[PLEN-1:SHIFT_4K];
  assign refill_tag      = refill_spa_i[PLEN-1:SHIFT_4K];
  assign unused_low_bits = ^{lkp_spa_i[SHIFT_4K-1:0], refill_spa_i[SHIFT_4K-1:0]};

  // A refill colliding with a flush of its own domain (or a global flush) is discarded.
  assign refill_drop  = flush_i && (!flush_sdid_en_i || (refill_sdid_i == flush_sdid_i));
  assign refill_do    = refill_valid_i && !refill_drop;
  assign refill_alloc = refill_do && !dedup_hit_c;

  // Lookup and dedup compare against the pre-edge contents; lowest index wins.
  always_comb begin
    lkp_hit_c   = 1'b0;
    lkp_perm_c  = DISALLOWED;
    dedup_hit_c = 1'b0;
    dedup_idx_c = '0;
    for (int unsigned i = 0; i < PLB_ENTRIES; i++) begin
      valid_vec[i] = entries_q[i].valid;
      if (!lkp_hit_c && entries_q[i].valid && (entries_q[i].sdid == lkp_sdid_i) &&
          (((entries_q[i].tag ^ lkp_tag) & tag_mask(entries_q[i].size, L2_SHIFT)) == '0)) begin
        lkp_hit_c  = 1'b1;
        lkp_perm_c = entries_q[i].perm;
      end
      if (!dedup_hit_c && entries_q[i].valid && (entries_q[i].sdid == refill_sdid_i) &&
          (entries_q[i].size == refill_size_i) &&
          (((entries_q[i].tag ^ refill_tag) & tag_mask(refill_size_i, L2_SHIFT)) == '0)) begin
        dedup_hit_c = 1'b1;
        dedup_idx_c = IDX_W'(i);
      end
    end
  end

  mpt_plb_victim_sel #(
    .ENTRIES (PLB_ENTRIES)
  ) u_victim_sel (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .valid_i      (valid_vec),
    .alloc_i      (refill_alloc),
    .victim_idx_c (victim_idx_c)
  );

  // Response and counters; bare mode answers RWX without touching the counters.
  always_comb begin
    resp_valid_d   = lkp_valid_i;
    resp_hit_d     = 1'b0;
    resp_allowed_d = 1'b0;
    resp_perm_d    = DISALLOWED;
    hit_cnt_d      = hit_cnt_q;
    miss_cnt_d     = miss_cnt_q;
    if (lkp_valid_i) begin
      if (mode_i == MPT_BARE) begin
        resp_hit_d     = 1'b1;
        resp_allowed_d = 1'b1;
        resp_perm_d    = ALLOW_RWX;
      end else begin
        resp_hit_d     = lkp_hit_c;
        resp_perm_d    = lkp_perm_c;
        resp_allowed_d = lkp_hit_c && perm_allows(lkp_perm_c, lkp_access_i);
        if (lkp_hit_c) begin
          if (hit_cnt_q != CNT_MAX) hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end else begin
          if (miss_cnt_q != CNT_MAX) miss_cnt_d = miss_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Flush clears first, then a surviving refill writes its slot.
  always_comb begin
    for (int unsigned i = 0; i < PLB_ENTRIES; i++) begin
      entries_d[i] = entries_q[i];
      if (flush_i && (!flush_sdid_en_i || (entries_q[i].sdid == flush_sdid_i))) begin
        entries_d[i].valid = 1'b0;
      end
    end
    if (refill_do) begin
      entries_d[dedup_hit_c ? dedup_idx_c : victim_idx_c] = '{
        valid: 1'b1,
        sdid:  refill_sdid_i,
        tag:   refill_tag,
        size:  refill_size_i,
        perm:  refill_perm_i
      };
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < PLB_ENTRIES; i++) entries_q[i] <= '0;
      resp_valid_q   <= 1'b0;
      resp_hit_q     <= 1'b0;
      resp_allowed_q <= 1'b0;
      resp_perm_q    <= DISALLOWED;
      hit_cnt_q      <= '0;
      miss_cnt_q     <= '0;
    end else begin
      for (int unsigned i = 0; i < PLB_ENTRIES; i++) entries_q[i] <= entries_d[i];
      resp_valid_q   <= resp_valid_d;
      resp_hit_q     <= resp_hit_d;
      resp_allowed_q <= resp_allowed_d;
      resp_perm_q    <= resp_perm_d;
      hit_cnt_q      <= hit_cnt_d;
      miss_cnt_q     <= miss_cnt_d;
    end
  end

  assign resp_valid_o   = resp_valid_q;
  assign resp_hit_o     = resp_hit_q;
  assign resp_allowed_o = resp_allowed_q;
  assign resp_perm_o    = resp_perm_q;
  assign hit_cnt_o      = hit_cnt_q;
  assign miss_cnt_o     = miss_cnt_q;

endmodule

// File: tb/tb_mpt_plb.sv
// Bench for mpt_plb: directed scenarios plus random traffic against an array-based model.
module tb_mpt_plb;
  import mpt_plb_pkg::*;

  localparam int unsigned    N    = 8;
  localparam int unsigned    CW   = 8;
  localparam logic [CW-1:0]  CMAX = '1;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  mpt_mode_e        mode_i;
  logic             lkp_valid_i;
  logic [33:0]      lkp_spa_i;
  logic [5:0]       lkp_sdid_i;
  mpt_access_e      lkp_access_i;
  logic             resp_valid_o, resp_hit_o, resp_allowed_o;
  mpt_permissions_e resp_perm_o;
  logic             refill_valid_i;
  logic [33:0]      refill_spa_i;
  logic [5:0]       refill_sdid_i;
  plb_size_e        refill_size_i;
  mpt_permissions_e refill_perm_i;
  logic             flush_i, flush_sdid_en_i;
  logic [5:0]       flush_sdid_i;
  logic [CW-1:0]    hit_cnt_o, miss_cnt_o;

  mpt_plb #(.PLB_ENTRIES(N), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .mode_i(mode_i),
    .lkp_valid_i(lkp_valid_i), .lkp_spa_i(lkp_spa_i), .lkp_sdid_i(lkp_sdid_i), .lkp_access_i(lkp_access_i),
    .resp_valid_o(resp_valid_o), .resp_hit_o(resp_hit_o), .resp_allowed_o(resp_allowed_o), .resp_perm_o(resp_perm_o),
    .refill_valid_i(refill_valid_i), .refill_spa_i(refill_spa_i), .refill_sdid_i(refill_sdid_i),
    .refill_size_i(refill_size_i), .refill_perm_i(refill_perm_i),
    .flush_i(flush_i), .flush_sdid_en_i(flush_sdid_en_i), .flush_sdid_i(flush_sdid_i),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain arrays holding the full walked address.
  bit               m_valid [N];
  logic [5:0]       m_sdid  [N];
  logic [33:0]      m_spa   [N];
  plb_size_e        m_size  [N];
  mpt_permissions_e m_perm  [N];
  int               m_ptr;
  logic [CW-1:0]    m_hit, m_miss;
  logic             e_valid, e_hit, e_allowed;
  mpt_permissions_e e_perm;

  function automatic logic [4:0] dut_resp();
    return {resp_valid_o, resp_hit_o, resp_allowed_o, resp_perm_o};
  endfunction

  function automatic logic [4:0] exp_resp();
    return {e_valid, e_hit, e_allowed, e_perm};
  endfunction

  function automatic int shift_of(plb_size_e s);
    if (s == SIZE_L2) return 25;
    if (s == SIZE_4M) return 22;
    return 12;
  endfunction

  function automatic bit allows(mpt_permissions_e p, mpt_access_e a);
    case (a)
      ACCESS_READ:  return p inside {ALLOW_RX, ALLOW_RW, ALLOW_RWX};
      ACCESS_WRITE: return p inside {ALLOW_RW, ALLOW_RWX};
      ACCESS_EXEC:  return p inside {ALLOW_RX, ALLOW_RWX};
      default:      return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    m_ptr = 0; m_hit = '0; m_miss = '0;
    e_valid = 1'b0; e_hit = 1'b0; e_allowed = 1'b0; e_perm = DISALLOWED;
  endtask

  // One clock: predict from pre-edge model state, drive, clock, sample #1 later.
  task automatic step(input bit lv, input logic [33:0] spa, input logic [5:0] sdid, input mpt_access_e acc,
                      input bit rv, input logic [33:0] rspa, input logic [5:0] rsdid, input plb_size_e rsz,
                      input mpt_permissions_e rperm, input bit fl, input bit fsel, input logic [5:0] fsdid);
    int tgt, sh;
    bit drop;
    e_valid = lv; e_hit = 1'b0; e_allowed = 1'b0; e_perm = DISALLOWED;
    if (lv && mode_i == MPT_BARE) begin
      e_hit = 1'b1; e_allowed = 1'b1; e_perm = ALLOW_RWX;
    end else if (lv) begin
      for (int i = 0; i < N; i++) begin
        sh = shift_of(m_size[i]);
        if (!e_hit && m_valid[i] && m_sdid[i] == sdid && (spa >> sh) == (m_spa[i] >> sh)) begin
          e_hit = 1'b1; e_perm = m_perm[i];
        end
      end
      e_allowed = e_hit && allows(e_perm, acc);
      if (e_hit) begin
        if (m_hit != CMAX) m_hit = m_hit + 1'b1;
      end else if (m_miss != CMAX) m_miss = m_miss + 1'b1;
    end
    drop = fl && (!fsel || rsdid == fsdid);
    tgt  = -1;
    if (rv && !drop) begin
      sh = shift_of(rsz);
      for (int i = 0; i < N; i++)
        if (tgt < 0 && m_valid[i] && m_sdid[i] == rsdid && m_size[i] == rsz && (m_spa[i] >> sh) == (rspa >> sh)) tgt = i;
      for (int i = 0; i < N; i++)
        if (tgt < 0 && !m_valid[i]) tgt = i;
      if (tgt < 0) begin
        tgt = m_ptr; m_ptr = (m_ptr + 1) % N;
      end
    end
    if (fl) for (int i = 0; i < N; i++) if (!fsel || m_sdid[i] == fsdid) m_valid[i] = 1'b0;
    if (tgt >= 0) begin
      m_valid[tgt] = 1'b1; m_sdid[tgt] = rsdid; m_spa[tgt] = rspa; m_size[tgt] = rsz; m_perm[tgt] = rperm;
    end
    lkp_valid_i = lv; lkp_spa_i = spa; lkp_sdid_i = sdid; lkp_access_i = acc;
    refill_valid_i = rv; refill_spa_i = rspa; refill_sdid_i = rsdid; refill_size_i = rsz; refill_perm_i = rperm;
    flush_i = fl; flush_sdid_en_i = fsel; flush_sdid_i = fsdid;
    @(posedge clk_i); #1;
    lkp_valid_i = 1'b0; refill_valid_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic lookup(input logic [33:0] spa, input logic [5:0] sdid, input mpt_access_e acc);
    step(1'b1, spa, sdid, acc, 1'b0, '0, '0, SIZE_4K, DISALLOWED, 1'b0, 1'b0, '0);
  endtask

  task automatic refill(input logic [33:0] spa, input logic [5:0] sdid, input plb_size_e sz, input mpt_permissions_e p);
    step(1'b0, '0, '0, ACCESS_NONE, 1'b1, spa, sdid, sz, p, 1'b0, 1'b0, '0);
  endtask

  task automatic flush(input bit sel, input logic [5:0] sdid);
    step(1'b0, '0, '0, ACCESS_NONE, 1'b0, '0, '0, SIZE_4K, DISALLOWED, 1'b1, sel, sdid);
  endtask

  task automatic test_reset();
    n_tests++;
    if (dut_resp() !== 5'b0) begin
      n_fail++; $display("FAIL reset_resp: got %b exp %b", dut_resp(), 5'b0);
    end
    n_tests++;
    if ({hit_cnt_o, miss_cnt_o} !== '0) begin
      n_fail++; $display("FAIL reset_cnt: got %h/%h exp 0/0", hit_cnt_o, miss_cnt_o);
    end
  endtask

  task automatic test_miss_hit();
    mode_i = MPT_34;
    lookup(34'h0_1234_5000, 6'd3, ACCESS_READ);
    n_tests++;
    if (dut_resp() !== 5'b10000 || miss_cnt_o !== 8'd1) begin
      n_fail++; $display("FAIL first_miss: got %b cnt %0d exp 10000 cnt 1", dut_resp(), miss_cnt_o);
    end
    refill(34'h0_1234_5000, 6'd3, SIZE_4K, ALLOW_RW);
    lookup(34'h0_1234_5000, 6'd3, ACCESS_WRITE);
    n_tests++;
    if (dut_resp() !== 5'b11110) begin
      n_fail++; $display("FAIL hit_write: got %b exp 11110", dut_resp());
    end
    lookup(34'h0_1234_5ABC, 6'd3, ACCESS_EXEC);
    n_tests++;
    if (dut_resp() !== 5'b11010) begin
      n_fail++; $display("FAIL hit_exec: got %b exp 11010", dut_resp());
    end
    lookup(34'h0_1234_5000, 6'd4, ACCESS_READ);
    n_tests++;
    if (dut_resp() !== 5'b10000) begin
      n_fail++; $display("FAIL other_sdid: got %b exp 10000", dut_resp());
    end
    n_tests++;
    if ({hit_cnt_o, miss_cnt_o} !== {m_hit, m_miss}) begin
      n_fail++; $display("FAIL cnt_after_hits: got %0d/%0d exp %0d/%0d", hit_cnt_o, miss_cnt_o, m_hit, m_miss);
    end
  endtask

  task automatic test_l2();
    refill(34'h2_0000_0000, 6'd1, SIZE_L2, ALLOW_RX);
    lookup(34'h2_01FF_FFFC, 6'd1, ACCESS_READ);
    n_tests++;
    if (dut_resp() !== 5'b11101) begin
      n_fail++; $display("FAIL l2_inside: got %b exp 11101", dut_resp());
    end
    lookup(34'h2_0200_0000, 6'd1, ACCESS_READ);
    n_tests++;
    if (dut_resp() !== 5'b10000) begin
      n_fail++; $display("FAIL l2_outside: got %b exp 10000", dut_resp());
    end
  endtask

  task automatic test_eviction();
    logic [33:0] a [12];
    for (int k = 0; k < 12; k++) a[k] = 34'h1_0000_0000 + 34'(k) * 34'h1000;
    flush(1'b0, '0);
    for (int k = 0; k < 10; k++) refill(a[k], 6'd5, SIZE_4K, ALLOW_RW);
    for (int k = 0; k < 10; k++) begin
      lookup(a[k], 6'd5, ACCESS_WRITE);
      n_tests++;
      if (dut_resp() !== exp_resp() || resp_hit_o !== (k >= 2)) begin
        n_fail++; $display("FAIL evict_%0d: got %b exp %b", k, dut_resp(), exp_resp());
      end
    end
    refill(a[3], 6'd5, SIZE_4K, ALLOW_RX);
    lookup(a[3], 6'd5, ACCESS_WRITE);
    n_tests++;
    if (dut_resp() !== 5'b11001) begin
      n_fail++; $display("FAIL refill_update: got %b exp 11001", dut_resp());
    end
    refill(a[10], 6'd5, SIZE_4K, ALLOW_RW);
    lookup(a[2], 6'd5, ACCESS_READ);
    n_tests++;
    if (dut_resp() !== 5'b10000) begin
      n_fail++; $display("FAIL evict_after_update: got %b exp 10000", dut_resp());
    end
    lookup(a[4], 6'd5, ACCESS_READ);
    n_tests++;
    if (dut_resp() !== 5'b11110) begin
      n_fail++; $display("FAIL survivor: got %b exp 11110", dut_resp());
    end
  endtask

  task automatic test_flush();
    flush(1'b0, '0);
    refill(34'h0_0010_0000, 6'd1, SIZE_4K, ALLOW_RWX);
    refill(34'h0_0020_0000, 6'd1, SIZE_4K, ALLOW_RWX);
    refill(34'h0_0030_0000, 6'd2, SIZE_4K, ALLOW_RWX);
    // Lookup alongside the flush still sees the old entry; concurrent same-sdid refill is dropped.
    step(1'b1, 34'h0_0010_0000, 6'd1, ACCESS_READ, 1'b1, 34'h0_0040_0000, 6'd1, SIZE_4K, ALLOW_RWX,
         1'b1, 1'b1, 6'd1);
    n_tests++;
    if (dut_resp() !== 5'b11111) begin
      n_fail++; $display("FAIL flush_preview: got %b exp 11111", dut_resp());
    end
    for (int k = 1; k <= 4; k++) begin
      lookup(34'(k) * 34'h0010_0000, (k == 3) ? 6'd2 : 6'd1, ACCESS_READ);
      n_tests++;
      if (dut_resp() !== exp_resp() || resp_hit_o !== (k == 3)) begin
        n_fail++; $display("FAIL sel_flush_%0d: got %b exp %b", k, dut_resp(), exp_resp());
      end
    end
    step(1'b0, '0, '0, ACCESS_NONE, 1'b1, 34'h0_0050_0000, 6'd1, SIZE_4K, ALLOW_RW, 1'b1, 1'b1, 6'd2);
    lookup(34'h0_0050_0000, 6'd1, ACCESS_WRITE);
    n_tests++;
    if (dut_resp() !== 5'b11110) begin
      n_fail++; $display("FAIL flush_other_refill: got %b exp 11110", dut_resp());
    end
    lookup(34'h0_0030_0000, 6'd2, ACCESS_READ);
    n_tests++;
    if (dut_resp() !== 5'b10000) begin
      n_fail++; $display("FAIL flush_sdid2: got %b exp 10000", dut_resp());
    end
  endtask

  task automatic test_bare();
    logic [CW-1:0] h0, m0;
    h0 = hit_cnt_o; m0 = miss_cnt_o;
    mode_i = MPT_BARE;
    for (int k = 0; k < 4; k++) begin
      lookup(34'($urandom()), 6'($urandom_range(0, 63)), mpt_access_e'(2'($urandom_range(0, 3))));
      n_tests++;
      if (dut_resp() !== 5'b11111 || hit_cnt_o !== h0 || miss_cnt_o !== m0) begin
        n_fail++; $display("FAIL bare_%0d: got %b cnt %0d/%0d exp 11111 cnt %0d/%0d",
                           k, dut_resp(), hit_cnt_o, miss_cnt_o, h0, m0);
      end
    end
    mode_i = MPT_34;
    lookup(34'h0_0050_0000, 6'd1, ACCESS_WRITE);
    n_tests++;
    if (dut_resp() !== 5'b11110) begin
      n_fail++; $display("FAIL bare_kept_entries: got %b exp 11110", dut_resp());
    end
  endtask

  task automatic test_saturation();
    while (m_miss != CMAX) lookup(34'h3_0000_0000, 6'd63, ACCESS_READ);
    n_tests++;
    if (miss_cnt_o !== CMAX) begin
      n_fail++; $display("FAIL miss_at_max: got %h exp %h", miss_cnt_o, CMAX);
    end
    lookup(34'h3_0000_0000, 6'd63, ACCESS_READ);
    n_tests++;
    if (miss_cnt_o !== CMAX || dut_resp() !== 5'b10000) begin
      n_fail++; $display("FAIL miss_saturate: got %h resp %b exp %h resp 10000", miss_cnt_o, dut_resp(), CMAX);
    end
  endtask

  task automatic test_random();
    logic [33:0] pool [4];
    logic [33:0] spa, rspa;
    pool[0] = 34'h0_1234_5000; pool[1] = 34'h2_0000_0000;
    pool[2] = 34'h1_0040_0000; pool[3] = 34'h3_FFC0_0000;
    for (int k = 0; k < 600; k++) begin
      spa  = pool[$urandom_range(0, 3)] + (34'($urandom_range(0, 3)) << 12) + (34'($urandom_range(0, 1)) << 22);
      rspa = pool[$urandom_range(0, 3)] + (34'($urandom_range(0, 3)) << 12) + (34'($urandom_range(0, 1)) << 22);
      mode_i = ($urandom_range(0, 9) == 0) ? MPT_BARE : MPT_34;
      step($urandom_range(0, 3) != 0, spa, 6'($urandom_range(0, 2)), mpt_access_e'(2'($urandom_range(0, 3))),
           $urandom_range(0, 2) == 0, rspa, 6'($urandom_range(0, 2)), plb_size_e'(2'($urandom_range(0, 2))),
           mpt_permissions_e'(2'($urandom_range(0, 3))),
           $urandom_range(0, 24) == 0, $urandom_range(0, 1) == 1, 6'($urandom_range(0, 2)));
      n_tests++;
      if (dut_resp() !== exp_resp() || hit_cnt_o !== m_hit || miss_cnt_o !== m_miss) begin
        n_fail++; $display("FAIL random_%0d: resp %b cnt %0d/%0d exp %b cnt %0d/%0d",
                           k, dut_resp(), hit_cnt_o, miss_cnt_o, exp_resp(), m_hit, m_miss);
      end
    end
    mode_i = MPT_34;
  endtask

  task automatic test_async_reset();
    refill(34'h0_0777_7000, 6'd7, SIZE_4K, ALLOW_RWX);
    lookup(34'h0_0777_7000, 6'd7, ACCESS_READ);
    lkp_valid_i = 1'b1; lkp_spa_i = 34'h0_0777_7000;
    #2 rst_i = 1'b1; lkp_valid_i = 1'b0;
    #1;
    n_tests++;
    if (dut_resp() !== 5'b0 || hit_cnt_o !== '0 || miss_cnt_o !== '0) begin
      n_fail++; $display("FAIL async_reset: got %b cnt %0d/%0d exp 00000 cnt 0/0", dut_resp(), hit_cnt_o, miss_cnt_o);
    end
    model_reset();
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    lookup(34'h0_0777_7000, 6'd7, ACCESS_READ);
    n_tests++;
    if (dut_resp() !== 5'b10000 || miss_cnt_o !== 8'd1) begin
      n_fail++; $display("FAIL post_reset_miss: got %b cnt %0d exp 10000 cnt 1", dut_resp(), miss_cnt_o);
    end
  endtask

  initial begin
    mode_i = MPT_34; lkp_valid_i = 1'b0; lkp_spa_i = '0; lkp_sdid_i = '0; lkp_access_i = ACCESS_NONE;
    refill_valid_i = 1'b0; refill_spa_i = '0; refill_sdid_i = '0; refill_size_i = SIZE_4K;
    refill_perm_i = DISALLOWED; flush_i = 1'b0; flush_sdid_en_i = 1'b0; flush_sdid_i = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    test_reset();
    test_miss_hit();
    test_l2();
    test_eviction();
    test_flush();
    test_bare();
    test_saturation();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
